stopwatch: RTL and testbench

STOPWATCH -- requirements
Module: stopwatch

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/bcd_cnt.sv | 23 ++
 rtl/stopwatch.sv | 142 ++++++++++++++
 tb/tb_stopwatch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: state encoding, digit geometry and the
// single-digit BCD step used by both the counters and the display path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int SEC_HI_IDX = 3;

  localparam logic [DIGIT_W-1:0] DEC_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_HI_MAX = 4'd5;

  // Digit order is cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi; only the seconds tens rolls at 5.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
    return (idx == SEC_HI_IDX) ? SEC_HI_MAX : DEC_MAX;
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_step(input logic [DIGIT_W-1:0] d,
                                                  input logic               inc,
                                                  input logic               clr,
                                                  input logic [DIGIT_W-1:0] max);
    if (clr) return '0;
    if (inc) return (d == max) ? '0 : d + 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/bcd_cnt.sv
// One BCD digit: counts 0..MAX on inc, carries combinationally so a whole
// chain of digits ripples within a single clock cycle.
module bcd_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DEC_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = inc & (digit == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit <= '0;
    else        digit <= bcd_step(digit, inc, clr, MAX);
  end

endmodule

// File: rtl/stopwatch.sv
// Stopwatch with start/stop, lap freeze and clear, counting centiseconds from
// an external 100 Hz square wave; all outputs come straight from flops.
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int MIN_WRAP = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f100Hz,
  input  logic       key_ss,
  input  logic       key_lap,
  input  logic       key_clr,
  output logic [3:0] cs_lo,
  output logic [3:0] cs_hi,
  output logic [3:0] s_lo,
  output logic [3:0] s_hi,
  output logic [3:0] m_lo,
  output logic [3:0] m_hi,
  output logic       running,
  output logic       wrap
);

  localparam int                 MIN_TOP  = MIN_WRAP - 1;
  localparam logic [DIGIT_W-1:0] M_LO_TOP = DIGIT_W'(MIN_TOP % 10);
  localparam logic [DIGIT_W-1:0] M_HI_TOP = DIGIT_W'(MIN_TOP / 10);

  state_t state, state_next;

  logic f_prev;
  logic tick;
  logic active;
  logic count_en;
  logic show_lap;
  logic lap_load;
  logic at_max;
  logic wrap_now;
  logic clr_all;

  logic [DIGIT_W-1:0] live      [NUM_DIGITS];
  logic [DIGIT_W-1:0] live_next [NUM_DIGITS];
  logic [DIGIT_W-1:0] lap       [NUM_DIGITS];
  logic [DIGIT_W-1:0] disp      [NUM_DIGITS];

  // f_prev resets low and IDLE never counts, so a wave already high at release cannot tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_prev <= 1'b0;
    else        f_prev <= f100Hz;
  end

  assign tick = f100Hz & ~f_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (key_clr) begin
      state_next = IDLE;
    end else if (key_ss) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        LAP:     state_next = PAUSE;
        default: state_next = IDLE;
      endcase
    end else if (key_lap) begin
      if (state == RUN)      state_next = LAP;
      else if (state == LAP) state_next = RUN;
    end
  end

  // The state at the start of the cycle decides whether a coincident tick counts.
  always_comb begin
    active   = (state == RUN) || (state == LAP);
    count_en = tick & active & ~key_clr;
    show_lap = (state_next == LAP);
    lap_load = show_lap && (state != LAP);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic inc_i;
    logic carry_i;
    if (i == 0) begin : g_first
      assign inc_i = count_en;
    end else begin : g_rest
      assign inc_i = g_digit[i-1].carry_i;
    end
    bcd_cnt #(.MAX(digit_max(i))) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_i),
      .clr   (clr_all),
      .digit (live[i]),
      .carry (carry_i)
    );
    assign live_next[i] = bcd_step(live[i], inc_i, clr_all, digit_max(i));
  end

  assign at_max = (live[0] == DEC_MAX) && (live[1] == DEC_MAX) &&
                  (live[2] == DEC_MAX) && (live[3] == SEC_HI_MAX) &&
                  (live[4] == M_LO_TOP) && (live[5] == M_HI_TOP);

  // The minutes-tens carry can only fire at 99:59.99, which is already at_max when MIN_WRAP is 100.
  assign wrap_now = (count_en & at_max) | g_digit[NUM_DIGITS-1].carry_i;
  assign clr_all  = key_clr | wrap_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) lap[i] <= '0;
    end else if (key_clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) lap[i] <= '0;
    end else if (lap_load) begin
      for (int i = 0; i < NUM_DIGITS; i++) lap[i] <= live_next[i];
    end
  end

  // Display flops load next-cycle values so digits move on the same edge as the live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        disp[i] <= (show_lap && !lap_load) ? lap[i] : live_next[i];
      running <= (state_next == RUN) || (state_next == LAP);
      wrap    <= wrap_now;
    end
  end

  assign cs_lo = disp[0];
  assign cs_hi = disp[1];
  assign s_lo  = disp[2];
  assign s_hi  = disp[3];
  assign m_lo  = disp[4];
  assign m_hi  = disp[5];

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for the stopwatch: a scoreboard queue holds expected display
// words pushed as stimulus is driven and popped when the outputs are sampled.
module tb_stopwatch;

  localparam int MIN_WRAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f100Hz;
  logic       key_ss;
  logic       key_lap;
  logic       key_clr;
  logic [3:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
  logic       running;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int total    = 0;

  typedef struct {
    string       tag;
    logic [25:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  stopwatch #(.MIN_WRAP(MIN_WRAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f100Hz  (f100Hz),
    .key_ss  (key_ss),
    .key_lap (key_lap),
    .key_clr (key_clr),
    .cs_lo   (cs_lo),
    .cs_hi   (cs_hi),
    .s_lo    (s_lo),
    .s_hi    (s_hi),
    .m_lo    (m_lo),
    .m_hi    (m_hi),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One f100Hz period at the fastest legal rate: one clk high, one clk low.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      f100Hz = 1'b1;
      step();
      f100Hz = 1'b0;
      step();
    end
  endtask

  task automatic press(input bit ss, input bit lp, input bit clr);
    key_ss  = ss;
    key_lap = lp;
    key_clr = clr;
    step();
    key_ss  = 1'b0;
    key_lap = 1'b0;
    key_clr = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int t, input bit run, input bit wr);
    sb_entry_t e;
    e.tag = tag;
    e.exp = {wr, run, to_bcd(t)};
    sb.push_back(e);
  endtask

  task automatic check_out();
    sb_entry_t   e;
    logic [25:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {wrap, running, m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo};
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    f100Hz  = 1'b0;
    key_ss  = 1'b0;
    key_lap = 1'b0;
    key_clr = 1'b0;
    repeat (3) step();
    expect_out("reset", 0, 0, 0);
    check_out();
    rst_n = 1'b1;
    repeat (2) step();

    press(1, 0, 0);
    tick_n(100);
    total = 100;
    expect_out("run_1s", total, 1, 0);
    check_out();

    tick_n(437);
    total += 437;
    expect_out("run_537", total, 1, 0);
    check_out();
    press(1, 0, 0);
    expect_out("pause_enter", total, 0, 0);
    check_out();
    tick_n(50);
    expect_out("pause_hold", total, 0, 0);
    check_out();
    press(1, 0, 0);
    expect_out("resume", total, 1, 0);
    check_out();
    tick_n(1);
    total += 1;
    expect_out("resume_tick", total, 1, 0);
    check_out();

    press(0, 0, 1);
    total = 0;
    expect_out("clear", total, 0, 0);
    check_out();
    press(0, 1, 0);
    tick_n(3);
    expect_out("idle_lap_ignored", total, 0, 0);
    check_out();

    press(1, 0, 0);
    tick_n(200);
    total = 200;
    expect_out("pre_lap", total, 1, 0);
    check_out();
    press(0, 1, 0);
    expect_out("lap_enter", 200, 1, 0);
    check_out();
    tick_n(300);
    total += 300;
    expect_out("lap_frozen", 200, 1, 0);
    check_out();
    press(0, 1, 0);
    expect_out("lap_release", total, 1, 0);
    check_out();

    // Tick, clear and start/stop all land on one edge while running.
    f100Hz  = 1'b1;
    key_clr = 1'b1;
    key_ss  = 1'b1;
    step();
    key_clr = 1'b0;
    key_ss  = 1'b0;
    total   = 0;
    expect_out("clr_ss_tick", total, 0, 0);
    check_out();
    f100Hz = 1'b0;
    step();

    press(1, 0, 0);
    tick_n(4217);
    total = 4217;
    expect_out("pre_reset", total, 1, 0);
    check_out();
    #3;
    rst_n  = 1'b0;
    f100Hz = 1'b1;
    #1;
    total = 0;
    expect_out("async_reset", total, 0, 0);
    check_out();
    step();
    rst_n  = 1'b1;
    key_ss = 1'b1;
    step();
    key_ss = 1'b0;
    expect_out("release_high", total, 1, 0);
    check_out();
    repeat (2) step();
    expect_out("no_spurious_tick", total, 1, 0);
    check_out();
    f100Hz = 1'b0;
    step();
    f100Hz = 1'b1;
    step();
    total = 1;
    expect_out("first_real_tick", total, 1, 0);
    check_out();
    f100Hz = 1'b0;
    step();

    press(0, 0, 1);
    press(1, 0, 0);
    total = MIN_WRAP * 6000 - 1;
    tick_n(total);
    expect_out("pre_wrap", total, 1, 0);
    check_out();
    f100Hz = 1'b1;
    step();
    total = 0;
    expect_out("wrap_pulse", total, 1, 1);
    check_out();
    f100Hz = 1'b0;
    step();
    expect_out("wrap_one_cycle", total, 1, 0);
    check_out();

    press(1, 1, 0);
    expect_out("ss_beats_lap", total, 0, 0);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
